// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage with IF/ID register.
// Issues requests to instruction memory, absorbs hazard-unit stalls through a
// one-entry skid register, and squashes in-flight fetches on branch redirects.
module fetch_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        PC_stall_i,
    input  logic        IFID_stall_i,
    input  logic        Flush_i,
    input  logic [31:0] Branch_target_i,
    output logic        Imem_req_o,
    output logic [31:0] Imem_addr_o,
    input  logic        Imem_ack_i,
    input  logic [31:0] Imem_data_i,
    output logic [31:0] PC_o,
    output logic [31:0] IFID_PC_o,
    output logic [31:0] IFID_Instr_o,
    output logic        IFID_Valid_o
);

    localparam logic [1:0] ST_FETCH   = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic [31:0] r_skid;
    logic [31:0] r_lat_addr;

    logic        w_hold;
    logic [31:0] w_pc_plus4;

    assign w_hold     = PC_stall_i | IFID_stall_i;
    assign w_pc_plus4 = r_pc + 32'd4;

    // Memory request: silent during reset and while a stalled word sits in the skid.
    assign Imem_req_o  = rst_i & (r_state != ST_HOLD);
    assign Imem_addr_o = (r_state == ST_DISCARD) ? r_lat_addr : r_pc;

    assign PC_o         = r_pc;
    assign IFID_PC_o    = r_ifid_pc;
    assign IFID_Instr_o = r_ifid_instr;
    assign IFID_Valid_o = r_ifid_valid;

    // Fetch FSM, PC, IF/ID, skid and squashed-address registers; Flush_i beats hold everywhere.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state      <= ST_FETCH;
            r_pc         <= '0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
            r_skid       <= '0;
            r_lat_addr   <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (Flush_i) begin
                        r_pc         <= Branch_target_i;
                        r_ifid_instr <= '0;
                        r_ifid_valid <= 1'b0;
                        if (!Imem_ack_i) begin
                            // Outstanding request must complete at its original address.
                            r_lat_addr <= r_pc;
                            r_state    <= ST_DISCARD;
                        end
                    end else if (Imem_ack_i) begin
                        if (!w_hold) begin
                            r_ifid_pc    <= w_pc_plus4;
                            r_ifid_instr <= Imem_data_i;
                            r_ifid_valid <= 1'b1;
                            r_pc         <= w_pc_plus4;
                        end else begin
                            r_skid  <= Imem_data_i;
                            r_state <= ST_HOLD;
                        end
                    end else if (!w_hold) begin
                        r_ifid_instr <= '0;
                        r_ifid_valid <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (Flush_i) begin
                        r_skid       <= '0;
                        r_pc         <= Branch_target_i;
                        r_ifid_instr <= '0;
                        r_ifid_valid <= 1'b0;
                        r_state      <= ST_FETCH;
                    end else if (!w_hold) begin
                        r_ifid_pc    <= w_pc_plus4;
                        r_ifid_instr <= r_skid;
                        r_ifid_valid <= 1'b1;
                        r_pc         <= w_pc_plus4;
                        r_state      <= ST_FETCH;
                    end
                end

                ST_DISCARD: begin
                    if (Flush_i) begin
                        r_pc         <= Branch_target_i;
                        r_ifid_instr <= '0;
                        r_ifid_valid <= 1'b0;
                    end else if (!w_hold) begin
                        r_ifid_instr <= '0;
                        r_ifid_valid <= 1'b0;
                    end
                    if (Imem_ack_i) begin
                        r_state <= ST_FETCH;
                    end
                end

                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against hand-computed values.
module tb_fetch_unit;

    logic        clk;
    logic        rst_i;
    logic        PC_stall_i;
    logic        IFID_stall_i;
    logic        Flush_i;
    logic [31:0] Branch_target_i;
    logic        Imem_req_o;
    logic [31:0] Imem_addr_o;
    logic        Imem_ack_i;
    logic [31:0] Imem_data_i;
    logic [31:0] PC_o;
    logic [31:0] IFID_PC_o;
    logic [31:0] IFID_Instr_o;
    logic        IFID_Valid_o;

    int ntests = 0;
    int nerr   = 0;

    fetch_unit dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .PC_stall_i      (PC_stall_i),
        .IFID_stall_i    (IFID_stall_i),
        .Flush_i         (Flush_i),
        .Branch_target_i (Branch_target_i),
        .Imem_req_o      (Imem_req_o),
        .Imem_addr_o     (Imem_addr_o),
        .Imem_ack_i      (Imem_ack_i),
        .Imem_data_i     (Imem_data_i),
        .PC_o            (PC_o),
        .IFID_PC_o       (IFID_PC_o),
        .IFID_Instr_o    (IFID_Instr_o),
        .IFID_Valid_o    (IFID_Valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic valid);
        check({tag, ".ifid_pc"}, IFID_PC_o, pc);
        check({tag, ".ifid_instr"}, IFID_Instr_o, instr);
        check({tag, ".ifid_valid"}, {31'd0, IFID_Valid_o}, {31'd0, valid});
    endtask

    initial begin
        rst_i = 1'b0; PC_stall_i = 1'b0; IFID_stall_i = 1'b0; Flush_i = 1'b0;
        Branch_target_i = '0; Imem_ack_i = 1'b0; Imem_data_i = '0;

        // Reset state
        tick();
        tick();
        check("rst.pc", PC_o, 32'h0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check("rst.req", {31'd0, Imem_req_o}, 32'd0);

        // Release: request at address 0 immediately
        rst_i = 1'b1;
        #1;
        check("rel.req", {31'd0, Imem_req_o}, 32'd1);
        check("rel.addr", Imem_addr_o, 32'h0);

        // Zero-wait streaming: 0x0, 0x4, 0x8, 0xC
        for (int i = 0; i < 4; i++) begin
            Imem_ack_i  = 1'b1;
            Imem_data_i = 32'hA000_0000 + 32'(4 * i);
            tick();
            check_ifid("stream", 32'(4 * (i + 1)), 32'hA000_0000 + 32'(4 * i), 1'b1);
            check("stream.pc", PC_o, 32'(4 * (i + 1)));
        end

        // Stall on the ack at 0x10, three cycles in HOLD
        check("hold.addr", Imem_addr_o, 32'h10);
        Imem_data_i = 32'hA000_0010;
        PC_stall_i  = 1'b1;
        tick();
        Imem_ack_i  = 1'b0;
        Imem_data_i = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            check("hold.req", {31'd0, Imem_req_o}, 32'd0);
            check("hold.pc", PC_o, 32'h10);
            check_ifid("hold", 32'h10, 32'hA000_000C, 1'b1);
            if (i < 2) tick();
        end
        PC_stall_i = 1'b0;
        tick();
        check_ifid("unhold", 32'h14, 32'hA000_0010, 1'b1);
        check("unhold.pc", PC_o, 32'h14);
        check("unhold.req", {31'd0, Imem_req_o}, 32'd1);
        tick();
        check_ifid("unhold.once", 32'h14, 32'h0, 1'b0);

        // Advance to 0x20
        for (int i = 0; i < 3; i++) begin
            Imem_ack_i  = 1'b1;
            Imem_data_i = 32'hA000_0014 + 32'(4 * i);
            tick();
        end
        check("adv.pc", PC_o, 32'h20);
        check_ifid("adv", 32'h20, 32'hA000_001C, 1'b1);

        // Flush to 0x40 while the request at 0x20 is unacked
        Imem_ack_i = 1'b0; Flush_i = 1'b1; Branch_target_i = 32'h40;
        tick();
        Flush_i = 1'b0; Branch_target_i = 32'h0;
        check("disc.pc", PC_o, 32'h40);
        check("disc.addr0", Imem_addr_o, 32'h20);
        check("disc.req", {31'd0, Imem_req_o}, 32'd1);
        check_ifid("disc", 32'h20, 32'h0, 1'b0);
        tick();
        check("disc.addr1", Imem_addr_o, 32'h20);
        Imem_ack_i = 1'b1; Imem_data_i = 32'hDEAD_0020;
        tick();
        check_ifid("disc.drop", 32'h20, 32'h0, 1'b0);
        check("disc.next_addr", Imem_addr_o, 32'h40);
        Imem_data_i = 32'hA000_0040;
        tick();
        check_ifid("disc.tgt", 32'h44, 32'hA000_0040, 1'b1);

        // Flush and hold together while in HOLD
        Imem_data_i = 32'hA000_0044; IFID_stall_i = 1'b1;
        tick();
        check_ifid("fh.hold", 32'h44, 32'hA000_0040, 1'b1);
        check("fh.req0", {31'd0, Imem_req_o}, 32'd0);
        Imem_ack_i = 1'b0; Flush_i = 1'b1; Branch_target_i = 32'h80;
        tick();
        Flush_i = 1'b0; IFID_stall_i = 1'b0;
        check_ifid("fh.bubble", 32'h44, 32'h0, 1'b0);
        check("fh.pc", PC_o, 32'h80);
        check("fh.req1", {31'd0, Imem_req_o}, 32'd1);
        check("fh.addr", Imem_addr_o, 32'h80);
        Imem_ack_i = 1'b1; Imem_data_i = 32'hA000_0080;
        tick();
        check_ifid("fh.tgt", 32'h84, 32'hA000_0080, 1'b1);

        // No ack with hold: IF/ID keeps its instruction
        Imem_ack_i = 1'b0; PC_stall_i = 1'b1;
        tick();
        PC_stall_i = 1'b0;
        check_ifid("noack.hold", 32'h84, 32'hA000_0080, 1'b1);
        check("noack.pc", PC_o, 32'h84);

        // Flush with ack in FETCH, target at top of address space
        Imem_ack_i = 1'b1; Imem_data_i = 32'hDEAD_0084;
        Flush_i = 1'b1; Branch_target_i = 32'hFFFF_FFFC;
        tick();
        Flush_i = 1'b0;
        check_ifid("fack", 32'h84, 32'h0, 1'b0);
        check("fack.pc", PC_o, 32'hFFFF_FFFC);
        check("fack.addr", Imem_addr_o, 32'hFFFF_FFFC);

        // Wrap-around
        Imem_data_i = 32'hA000_00FC;
        tick();
        check("wrap.pc", PC_o, 32'h0);
        check_ifid("wrap", 32'h0, 32'hA000_00FC, 1'b1);

        // Flush inside DISCARD, then reset while still in DISCARD
        Imem_data_i = 32'hA000_0000;
        tick();
        check("pre.pc", PC_o, 32'h4);
        Imem_ack_i = 1'b0; Flush_i = 1'b1; Branch_target_i = 32'h100;
        tick();
        check("dd.addr0", Imem_addr_o, 32'h4);
        Branch_target_i = 32'h200;
        tick();
        Flush_i = 1'b0;
        check("dd.pc", PC_o, 32'h200);
        check("dd.addr1", Imem_addr_o, 32'h4);
        rst_i = 1'b0;
        tick();
        check("mrst.pc", PC_o, 32'h0);
        check_ifid("mrst", 32'h0, 32'h0, 1'b0);
        check("mrst.req", {31'd0, Imem_req_o}, 32'd0);
        rst_i = 1'b1; Imem_ack_i = 1'b1; Imem_data_i = 32'hA000_0000;
        #1;
        check("mrst.addr", Imem_addr_o, 32'h0);
        check("mrst.req1", {31'd0, Imem_req_o}, 32'd1);
        tick();
        check_ifid("late", 32'h4, 32'hA000_0000, 1'b1);
        check("late.pc", PC_o, 32'h4);

        $display("[TB] %0d tests run, %0d failed", ntests, nerr);
        $finish;
    end

endmodule
